// File: rtl/asrm_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : asrm_mem_bridge
// Purpose  : Serialises one word-wide CPU read/write request onto a byte-wide
//            synchronous RAM port, least significant byte first, and returns
//            read words with a one-cycle completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module asrm_mem_bridge #(
    parameter int WORDSIZE = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req_i,
    input  logic [WORDSIZE-1:0] cpu_addr_i,
    input  logic [WORDSIZE-1:0] cpu_wdata_i,
    input  logic                cpu_we_i,
    output logic [WORDSIZE-1:0] cpu_rdata_o,
    output logic                cpu_ready_o,
    output logic                busy_o,
    output logic [WORDSIZE-1:0] mem_addr_o,
    output logic [7:0]          mem_wdata_o,
    output logic                mem_we_o,
    input  logic [7:0]          mem_rdata_i
);

    localparam int NBYTES = WORDSIZE / 8;
    localparam int CW     = $clog2(NBYTES + 1);

    // Last byte index of a word, and the extra read step that collects it.
    localparam logic [CW-1:0] C_LAST  = CW'(NBYTES - 1);
    localparam logic [CW-1:0] C_FINAL = CW'(NBYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [WORDSIZE-1:0] wdata_q;      // remaining write bytes, next byte in [7:0]
    logic [WORDSIZE-1:0] asm_q;        // read word under assembly
    logic [WORDSIZE-1:0] cpu_rdata_q;
    logic                cpu_ready_q;
    logic                busy_q;
    logic [WORDSIZE-1:0] mem_addr_q;
    logic [7:0]          mem_wdata_q;
    logic                mem_we_q;

    logic [WORDSIZE+7:0] rd_cat;
    logic [WORDSIZE-1:0] asm_d;

    // Shift the arriving read byte in at the top; after N shifts byte 0 sits at [7:0].
    always_comb begin
        rd_cat = {mem_rdata_i, asm_q};
        asm_d  = rd_cat[WORDSIZE+7:8];
    end

    // Request sequencer: all outputs are registered and describe the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            mem_we_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cpu_ready_q <= 1'b0;
                    mem_wdata_q <= 8'h00;
                    mem_we_q    <= 1'b0;
                    if (cpu_req_i) begin
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        mem_addr_q <= cpu_addr_i;
                        if (cpu_we_i) begin
                            state_q     <= ST_WRITE;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= cpu_wdata_i[7:0];
                            wdata_q     <= cpu_wdata_i >> 8;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end else begin
                        busy_q     <= 1'b0;
                        mem_addr_q <= '0;
                    end
                end

                ST_WRITE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        state_q     <= ST_DONE;
                        cpu_ready_q <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= 8'h00;
                    end else begin
                        // Increment wraps modulo 2^WORDSIZE by construction.
                        mem_addr_q  <= mem_addr_q + 1'b1;
                        mem_wdata_q <= wdata_q[7:0];
                        wdata_q     <= wdata_q >> 8;
                    end
                end

                ST_READ: begin
                    // The byte for the address presented last cycle is on mem_rdata_i now.
                    if (cnt_q != '0) begin
                        asm_q <= asm_d;
                    end
                    if (cnt_q == C_FINAL) begin
                        state_q     <= ST_DONE;
                        cpu_rdata_q <= asm_d;
                        cpu_ready_q <= 1'b1;
                        mem_addr_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        // The collection step after the last byte holds the address.
                        if (cnt_q != C_LAST) begin
                            mem_addr_q <= mem_addr_q + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    cpu_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= 8'h00;
                    mem_we_q    <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata_o = cpu_rdata_q;
    assign cpu_ready_o = cpu_ready_q;
    assign busy_o      = busy_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_asrm_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_asrm_mem_bridge
// Purpose  : Directed self-checking bench for asrm_mem_bridge (16-bit words)
//            against a byte-wide synchronous RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asrm_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        busy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    logic [7:0]  ram [0:65535];
    int          we_pulses = 0;
    int          tests = 0;
    int          fails = 0;
    int          pulses_before;

    asrm_mem_bridge #(.WORDSIZE(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req_i   (cpu_req),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_we_i    (cpu_we),
        .cpu_rdata_o (cpu_rdata),
        .cpu_ready_o (cpu_ready),
        .busy_o      (busy),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_we_o    (mem_we),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_pulses     <= we_pulses + 1;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {busy, cpu_ready, mem_we, mem_addr, mem_wdata}
    function automatic logic [26:0] outs();
        return {busy, cpu_ready, mem_we, mem_addr, mem_wdata};
    endfunction

    initial begin
        reset     = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 16'h0000;
        cpu_we    = 1'b0;
        repeat (3) tick();
        check("reset_outs", {11'h0, outs()}, 38'h0);
        check("reset_rdata", {48'h0, cpu_rdata}, 64'h0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_outs", {37'h0, outs()}, 64'h0);
        end
        check("idle_rdata", {48'h0, cpu_rdata}, 64'h0);

        // ---- write 0xBEEF to 0x0010 ----
        cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF; cpu_we = 1'b1; cpu_req = 1'b1;
        tick();                                   // cycle 1
        cpu_req = 1'b0; cpu_addr = 16'h5555; cpu_wdata = 16'h0000;
        check("wr_c1", {37'h0, outs()}, {37'h0, 3'b101, 16'h0010, 8'hEF});
        tick();                                   // cycle 2
        check("wr_c2", {37'h0, outs()}, {37'h0, 3'b101, 16'h0011, 8'hBE});
        tick();                                   // cycle 3
        check("wr_c3", {37'h0, outs()}, {37'h0, 3'b110, 16'h0000, 8'h00});
        check("wr_rdata_kept", {48'h0, cpu_rdata}, 64'h0);
        tick();                                   // cycle 4
        check("wr_c4", {37'h0, outs()}, 64'h0);
        check("ram_10", {56'h0, ram[16'h0010]}, 64'hEF);
        check("ram_11", {56'h0, ram[16'h0011]}, 64'hBE);

        // ---- read back 0x0010 ----
        cpu_addr = 16'h0010; cpu_we = 1'b0; cpu_req = 1'b1;
        tick();                                   // cycle 1
        cpu_req = 1'b0;
        check("rd_c1", {37'h0, outs()}, {37'h0, 3'b100, 16'h0010, 8'h00});
        tick();                                   // cycle 2
        check("rd_c2", {37'h0, outs()}, {37'h0, 3'b100, 16'h0011, 8'h00});
        tick();                                   // cycle 3
        check("rd_c3", {37'h0, outs()}, {37'h0, 3'b100, 16'h0011, 8'h00});
        tick();                                   // cycle 4
        check("rd_c4", {37'h0, outs()}, {37'h0, 3'b110, 16'h0000, 8'h00});
        check("rd_data", {48'h0, cpu_rdata}, 64'hBEEF);
        tick();                                   // cycle 5
        check("rd_c5", {37'h0, outs()}, 64'h0);
        check("rd_data_hold", {48'h0, cpu_rdata}, 64'hBEEF);

        // ---- wrap: write 0x1234 to 0xFFFF ----
        cpu_addr = 16'hFFFF; cpu_wdata = 16'h1234; cpu_we = 1'b1; cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        check("wrap_wr_c1", {37'h0, outs()}, {37'h0, 3'b101, 16'hFFFF, 8'h34});
        tick();
        check("wrap_wr_c2", {37'h0, outs()}, {37'h0, 3'b101, 16'h0000, 8'h12});
        tick();
        check("wrap_wr_c3", {37'h0, outs()}, {37'h0, 3'b110, 16'h0000, 8'h00});
        check("wrap_wr_rdata", {48'h0, cpu_rdata}, 64'hBEEF);
        tick();
        check("wrap_wr_c4", {37'h0, outs()}, 64'h0);

        cpu_we = 1'b0; cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        check("wrap_rd_c1", {37'h0, outs()}, {37'h0, 3'b100, 16'hFFFF, 8'h00});
        tick();
        check("wrap_rd_c2", {37'h0, outs()}, {37'h0, 3'b100, 16'h0000, 8'h00});
        tick();
        check("wrap_rd_c3", {37'h0, outs()}, {37'h0, 3'b100, 16'h0000, 8'h00});
        tick();
        check("wrap_rd_c4", {37'h0, outs()}, {37'h0, 3'b110, 16'h0000, 8'h00});
        check("wrap_rd_data", {48'h0, cpu_rdata}, 64'h1234);
        tick();

        // ---- back-to-back: held cpu_req, write then read of 0x0040 ----
        cpu_addr = 16'h0040; cpu_wdata = 16'hA5C3; cpu_we = 1'b1; cpu_req = 1'b1;
        tick();                                   // cycle 1
        cpu_we = 1'b0; cpu_addr = 16'h0077; cpu_wdata = 16'hFFFF;
        check("b2b_c1", {37'h0, outs()}, {37'h0, 3'b101, 16'h0040, 8'hC3});
        tick();                                   // cycle 2
        check("b2b_c2", {37'h0, outs()}, {37'h0, 3'b101, 16'h0041, 8'hA5});
        tick();                                   // cycle 3 (DONE)
        cpu_addr = 16'h0040;
        check("b2b_c3", {37'h0, outs()}, {37'h0, 3'b110, 16'h0000, 8'h00});
        tick();                                   // cycle 4 (IDLE, accepts read)
        check("b2b_c4", {37'h0, outs()}, 64'h0);
        tick();                                   // read cycle 1
        cpu_req = 1'b0; cpu_addr = 16'h0099;
        check("b2b_rd1", {37'h0, outs()}, {37'h0, 3'b100, 16'h0040, 8'h00});
        tick();
        check("b2b_rd2", {37'h0, outs()}, {37'h0, 3'b100, 16'h0041, 8'h00});
        tick();
        check("b2b_rd3", {37'h0, outs()}, {37'h0, 3'b100, 16'h0041, 8'h00});
        tick();
        check("b2b_rd4", {37'h0, outs()}, {37'h0, 3'b110, 16'h0000, 8'h00});
        check("b2b_data", {48'h0, cpu_rdata}, 64'hA5C3);
        tick();
        check("b2b_idle", {37'h0, outs()}, 64'h0);

        // ---- reset in cycle 1 of a write to 0x0020, with cpu_req still high ----
        pulses_before = we_pulses;
        cpu_addr = 16'h0020; cpu_wdata = 16'h7788; cpu_we = 1'b1; cpu_req = 1'b1;
        tick();                                   // cycle 1
        check("abort_c1", {37'h0, outs()}, {37'h0, 3'b101, 16'h0020, 8'h88});
        reset = 1'b0;
        tick();                                   // cycle 2
        check("abort_c2", {37'h0, outs()}, 64'h0);
        check("abort_rdata", {48'h0, cpu_rdata}, 64'h0);
        reset = 1'b1; cpu_req = 1'b0;
        tick();
        check("abort_c3", {37'h0, outs()}, 64'h0);
        tick();
        check("abort_c4", {37'h0, outs()}, 64'h0);
        check("abort_pulses", 64'(we_pulses - pulses_before), 64'd1);
        check("abort_ram", {56'h0, ram[16'h0020]}, 64'h88);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/asrm_mem_bridge.md
# asrm_mem_bridge

Memory-side responder for the asrm CPU's word-wide RAM interface. It accepts one word read or write request at a time and serialises it onto a byte-wide synchronous RAM port in little-endian order. It assembles read words and signals completion with a one-cycle ready pulse. It sits between the CPU's memory port and the byte-organised RAM.

## Interface
- wordsize, 16, CPU word width in bits; multiple of 8, ≥ 8; N = wordsize/8 bytes per word

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low
- cpu_req  in  1  request strobe; sampled only in IDLE
- cpu_addr  in  wordsize  byte address of word's lowest byte
- cpu_wdata  in  wordsize  write data
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_rdata  out  wordsize  last completed read word; registered
- cpu_ready  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- mem_addr  out  wordsize  byte address to RAM
- mem_wdata  out  8  byte to RAM
- mem_we  out  1  RAM byte write enable
- mem_rdata  in  8  RAM read byte; valid the cycle after mem_addr is presented with mem_we = 0

## Operation
- States: IDLE, WRITE, READ, DONE. Byte counter c, width ≥ clog2(N+1). Latched base address, write data and direction.
- IDLE: if cpu_req, latch cpu_addr/cpu_wdata/cpu_we, set c = 0, go to WRITE (we = 1) or READ (we = 0). Otherwise stay. mem_addr = 0, mem_wdata = 0, mem_we = 0.
- WRITE: mem_addr = base + c, mem_wdata = byte c of latched data (byte 0 = bits 7:0), mem_we = 1. Increment c. After c = N−1, go to DONE.
- READ: c runs 0..N.
  - For c < N: mem_addr = base + c, mem_we = 0.
  - For c = N: mem_addr = base + N − 1 (hold), mem_we = 0.
  - For c ≥ 1: capture mem_rdata into assembly byte c−1.
  - After c = N: load assembled word into cpu_rdata, go to DONE.
- DONE: cpu_ready = 1, mem_we = 0, mem_addr = 0, go to IDLE. cpu_req is ignored.
- cpu_rdata changes only at read completion. Writes never alter it.
- Address arithmetic: base + c is modulo 2^wordsize; it wraps from all-ones to 0.
- cpu_addr, cpu_wdata and cpu_we may change freely after the accept cycle.

## Timing
- Reset values: state IDLE, c 0, cpu_rdata 0, cpu_ready 0, busy 0, mem_addr 0, mem_wdata 0, mem_we 0.
- Let cycle 0 be the IDLE cycle with cpu_req = 1.
- Write:
  - WRITE in cycles 1..N, with exactly N mem_we pulses.
  - cpu_ready in cycle N+1.
  - Total N+2 cycles, request to IDLE.
- Read:
  - READ in cycles 1..N+1.
  - cpu_ready in cycle N+2, with cpu_rdata valid in that same cycle and held afterwards.
- Next request: accepted earliest in cycle N+2 (write) or N+3 (read), i.e. the IDLE cycle after DONE. A held cpu_req is accepted then.
- busy is high from cycle 1 through the DONE cycle inclusive.
- Reset mid-operation:
  - At the next edge, return to IDLE with all reset values.
  - No further mem_we; no cpu_ready for the aborted request.
  - cpu_rdata is cleared to 0.
- Reset has priority over cpu_req in the same cycle.

## Test plan
- Reset, wordsize 16: deassert reset with cpu_req = 0 -> all outputs 0, busy 0 for 5 cycles.
- Write 0xBEEF to 0x0010 -> mem_we high in cycles 1–2 at addresses 0x0010 (data 0xEF) and 0x0011 (data 0xBE). cpu_ready in cycle 3 only. busy low from cycle 4.
- Read 0x0010 from a RAM model holding the above -> mem_addr 0x0010 then 0x0011, mem_we always 0. cpu_ready and cpu_rdata = 0xBEEF in cycle 4.
- Wrap: write 0x1234 to 0xFFFF -> byte 0x34 to 0xFFFF, byte 0x12 to 0x0000. Read back from 0xFFFF gives 0x1234.
- Back-to-back: cpu_req held high for a write followed by a read of the same address -> the second request is accepted in the IDLE cycle after DONE, and the read returns the written data. Changes to cpu_addr during busy have no effect.
- Reset in cycle 1 of a write to 0x0020 -> only one mem_we pulse (0x0020), no cpu_ready, IDLE next cycle, cpu_rdata 0.
